// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index and the memory-stage FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } memstage_state_t;

  // Width of the stall watchdog counter.
  localparam int WD_CNT_W = 16;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register.
// A bubble clears the write-enable, register index and data.
// The halt flag is only updated on non-bubble loads, so it is held through bubbles.
module memwb_reg
  import cpu_types_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     bubble_i,
  input  logic     wen_i,
  input  regbits_t wsel_i,
  input  word_t    wdat_i,
  input  logic     halt_i,
  output logic     wb_wen_o,
  output regbits_t wb_wsel_o,
  output word_t    wb_wdat_o,
  output logic     wb_halt_o
);

  logic     wen_q, wen_d;
  regbits_t wsel_q, wsel_d;
  word_t    wdat_q, wdat_d;
  logic     halt_q, halt_d;

  // Next-state selection: bubble or the incoming stage contents.
  always_comb begin
    wen_d  = wen_i;
    wsel_d = wsel_i;
    wdat_d = wdat_i;
    halt_d = halt_i;
    if (bubble_i) begin
      wen_d  = 1'b0;
      wsel_d = '0;
      wdat_d = '0;
      halt_d = halt_q;
    end
  end

  // Latch register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
      halt_q <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      wsel_q <= wsel_d;
      wdat_q <= wdat_d;
      halt_q <= halt_d;
    end
  end

  assign wb_wen_o  = wen_q;
  assign wb_wsel_o = wsel_q;
  assign wb_wdat_o = wdat_q;
  assign wb_halt_o = halt_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: dcache request/dhit handshake, branch/jump redirect,
// stall generation and the MEM/WB latch.
// Optional stall watchdog compiled in with `define MEMSTAGE_WATCHDOG_EN.
module memory_stage
  import cpu_types_pkg::*;
#(
  parameter int WATCHDOG_LIMIT = 1024
) (
  input  logic     CLK,
  input  logic     RST,
  input  word_t    outputo,
  input  logic     zeroo,
  input  word_t    wdato,
  input  logic     dWENo,
  input  logic     dRENo,
  input  logic     WENo,
  input  word_t    wselo,
  input  logic     write_sigo,
  input  logic     halto,
  input  logic     beqo,
  input  logic     bneo,
  input  logic     jsigo,
  input  logic     jrsigo,
  input  word_t    pcAddrOuto,
  input  word_t    brvalo,
  input  word_t    laddro,
  input  logic     flush,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output logic     pc_redirect,
  output word_t    pc_target,
  output logic     wb_WEN,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  output logic     wb_halt,
  output logic     mem_err
);

  memstage_state_t state_q;
  logic            run;
  logic            taken;
  logic            bubble;
  word_t           wb_data;
  logic            unused_bits;

  // RST gates the run qualifier directly so requests drop without waiting for an edge.
  assign run = (state_q == RUN) & ~RST;

  assign dmemREN   = dRENo & ~flush & run;
  assign dmemWEN   = dWENo & ~flush & run;
  assign dmemaddr  = outputo;
  assign dmemstore = wdato;
  assign mem_stall = (dmemREN | dmemWEN) & ~dhit;

  assign taken       = (beqo & zeroo) | (bneo & ~zeroo);
  assign pc_redirect = (taken | jsigo | jrsigo) & ~flush & run;
  assign pc_target   = taken ? brvalo : laddro;

  // Writeback data priority: load data, then link value, then ALU result.
  always_comb begin
    wb_data = outputo;
    if (dRENo)           wb_data = dmemload;
    else if (write_sigo) wb_data = pcAddrOuto;
  end

  // Once halted the stage only ever emits bubbles.
  assign bubble = flush | mem_stall | (state_q == HALTED);

  // RUN -> HALTED when a halt leaves the stage; only reset returns to RUN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (halto && !flush && !mem_stall) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  memwb_reg u_memwb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .bubble_i  (bubble),
    .wen_i     (WENo),
    .wsel_i    (wselo[4:0]),
    .wdat_i    (wb_data),
    .halt_i    (halto),
    .wb_wen_o  (wb_WEN),
    .wb_wsel_o (wb_wsel),
    .wb_wdat_o (wb_wdat),
    .wb_halt_o (wb_halt)
  );

`ifdef MEMSTAGE_WATCHDOG_EN
  localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(WATCHDOG_LIMIT);

  logic [WD_CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                mem_err_q;

  // Count consecutive stall cycles, saturating at the limit.
  always_comb begin
    wd_cnt_d = '0;
    if (mem_stall) begin
      wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  // Counter register and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == WD_LIMIT) mem_err_q <= 1'b1;
    end
  end

  assign mem_err     = mem_err_q;
  assign unused_bits = ^wselo[31:5];
`else
  assign mem_err     = 1'b0;
  assign unused_bits = (^wselo[31:5]) ^ (WATCHDOG_LIMIT == 0);
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver applies one vector per cycle
// and queues the expected outputs; the monitor compares at the falling edge.
// Watchdog checks are enabled when MEMSTAGE_WATCHDOG_EN is defined.
module tb_memory_stage;
  import cpu_types_pkg::*;

  typedef struct {
    logic  rst, dren, dwen, wen, halt, beq, bne, j, jr, zero, wsig, flush, dhit;
    word_t outv, wdat, wsel, pcaddr, brval, laddr, load;
  } in_t;

  typedef struct {
    logic     ren, wen, stall, redir;
    word_t    target, addr, store;
    logic     wbwen;
    regbits_t wbsel;
    word_t    wbdat;
    logic     wbhalt, err;
  } exp_t;

  logic     CLK = 1'b0;
  logic     RST;
  word_t    outputo, wdato, wselo, pcAddrOuto, brvalo, laddro, dmemload;
  logic     zeroo, dWENo, dRENo, WENo, write_sigo, halto, beqo, bneo, jsigo, jrsigo, flush, dhit;
  logic     dmemREN, dmemWEN, mem_stall, pc_redirect, wb_WEN, wb_halt, mem_err;
  word_t    dmemaddr, dmemstore, pc_target, wb_wdat;
  regbits_t wb_wsel;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   txn    = 0;

  always #5 CLK = ~CLK;

  memory_stage #(.WATCHDOG_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST), .outputo(outputo), .zeroo(zeroo), .wdato(wdato),
    .dWENo(dWENo), .dRENo(dRENo), .WENo(WENo), .wselo(wselo), .write_sigo(write_sigo),
    .halto(halto), .beqo(beqo), .bneo(bneo), .jsigo(jsigo), .jrsigo(jrsigo),
    .pcAddrOuto(pcAddrOuto), .brvalo(brvalo), .laddro(laddro), .flush(flush),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .wb_WEN(wb_WEN),
    .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_halt(wb_halt), .mem_err(mem_err)
  );

  function automatic in_t nop();
    in_t v;
    v.rst = 0; v.dren = 0; v.dwen = 0; v.wen = 0; v.halt = 0; v.beq = 0; v.bne = 0;
    v.j = 0; v.jr = 0; v.zero = 0; v.wsig = 0; v.flush = 0; v.dhit = 0;
    v.outv = 0; v.wdat = 0; v.wsel = 0; v.pcaddr = 0; v.brval = 0; v.laddr = 0; v.load = 0;
    return v;
  endfunction

  function automatic exp_t ex(logic ren, logic wen, logic st, logic rd, word_t tgt,
                              word_t addr, word_t store, logic wwen, regbits_t wsel,
                              word_t wdat, logic halt, logic err);
    exp_t e;
    e.ren = ren; e.wen = wen; e.stall = st; e.redir = rd; e.target = tgt; e.addr = addr;
    e.store = store; e.wbwen = wwen; e.wbsel = wsel; e.wbdat = wdat; e.wbhalt = halt; e.err = err;
    return e;
  endfunction

  task automatic apply(input in_t v);
    RST = v.rst; dRENo = v.dren; dWENo = v.dwen; WENo = v.wen; halto = v.halt;
    beqo = v.beq; bneo = v.bne; jsigo = v.j; jrsigo = v.jr; zeroo = v.zero;
    write_sigo = v.wsig; flush = v.flush; dhit = v.dhit; outputo = v.outv;
    wdato = v.wdat; wselo = v.wsel; pcAddrOuto = v.pcaddr; brvalo = v.brval;
    laddro = v.laddr; dmemload = v.load;
  endtask

  task automatic step(input in_t v, input exp_t e);
    @(posedge CLK);
    #1;
    apply(v);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input word_t act, input word_t req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL txn %0d %s: got %h, expected %h", txn, name, act, req);
  endtask

  // Monitor: pop one expectation per cycle and compare every output.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dmemREN",     word_t'(dmemREN),     word_t'(e.ren));
      chk("dmemWEN",     word_t'(dmemWEN),     word_t'(e.wen));
      chk("mem_stall",   word_t'(mem_stall),   word_t'(e.stall));
      chk("pc_redirect", word_t'(pc_redirect), word_t'(e.redir));
      chk("pc_target",   pc_target,            e.target);
      chk("dmemaddr",    dmemaddr,             e.addr);
      chk("dmemstore",   dmemstore,            e.store);
      chk("wb_WEN",      word_t'(wb_WEN),      word_t'(e.wbwen));
      chk("wb_wsel",     word_t'(wb_wsel),     word_t'(e.wbsel));
      chk("wb_wdat",     wb_wdat,              e.wbdat);
      chk("wb_halt",     word_t'(wb_halt),     word_t'(e.wbhalt));
      chk("mem_err",     word_t'(mem_err),     word_t'(e.err));
      $display("txn %0d: ren=%b wen=%b stall=%b redir=%b tgt=%h wb=%b/%0d/%h halt=%b err=%b",
               txn, dmemREN, dmemWEN, mem_stall, pc_redirect, pc_target,
               wb_WEN, wb_wsel, wb_wdat, wb_halt, mem_err);
      txn++;
    end
  end

  initial begin
    in_t v;
    // Reset state
    v = nop(); v.rst = 1;
    apply(v);
    exp_q.push_back(ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));
    @(posedge CLK); #1 RST = 1'b0;

    // Load with three miss cycles, then hit
    v = nop(); v.dren = 1; v.outv = 32'h100; v.wen = 1; v.wsel = 5; v.load = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) step(v, ex(1,0,1,0, 0, 32'h100, 0, 0,0,0, 0,0));
    v.dhit = 1;
    step(v, ex(1,0,0,0, 0, 32'h100, 0, 0,0,0, 0,0));

    // Store with immediate hit; load result visible on wb
    v = nop(); v.dwen = 1; v.outv = 32'h200; v.wdat = 32'h55; v.dhit = 1;
    step(v, ex(0,1,0,0, 0, 32'h200, 32'h55, 1,5,32'hDEADBEEF, 0,0));

    // beq taken
    v = nop(); v.beq = 1; v.zero = 1; v.brval = 32'h40;
    step(v, ex(0,0,0,1, 32'h40, 0, 0, 0,0,32'h200, 0,0));
    // beq not taken
    v.zero = 0;
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));
    // jump
    v = nop(); v.j = 1; v.laddr = 32'h80;
    step(v, ex(0,0,0,1, 32'h80, 0, 0, 0,0,0, 0,0));
    // bne taken
    v = nop(); v.bne = 1; v.zero = 0; v.brval = 32'h44;
    step(v, ex(0,0,0,1, 32'h44, 0, 0, 0,0,0, 0,0));
    // JAL link to r31
    v = nop(); v.j = 1; v.laddr = 32'h80; v.wsig = 1; v.pcaddr = 32'h14; v.wsel = 31; v.wen = 1;
    step(v, ex(0,0,0,1, 32'h80, 0, 0, 0,0,0, 0,0));
    // Flush with pending load and taken branch
    v = nop(); v.flush = 1; v.dren = 1; v.outv = 32'h300; v.beq = 1; v.zero = 1;
    v.brval = 32'h40; v.wen = 1; v.wsel = 7;
    step(v, ex(0,0,0,0, 32'h40, 32'h300, 0, 1,31,32'h14, 0,0));
    v = nop();
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));

    // Halt, then requests are ignored
    v = nop(); v.halt = 1;
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));
    v = nop(); v.dren = 1; v.outv = 32'h100; v.wen = 1; v.wsel = 3;
    step(v, ex(0,0,0,0, 0, 32'h100, 0, 0,0,0, 1,0));
    v.j = 1; v.laddr = 32'h80;
    step(v, ex(0,0,0,0, 32'h80, 32'h100, 0, 0,0,0, 1,0));
    // Asynchronous reset out of HALTED
    v = nop(); v.rst = 1;
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));
    // Stall, then reset asserted mid-stall
    v = nop(); v.dren = 1; v.outv = 32'h100;
    step(v, ex(1,0,1,0, 0, 32'h100, 0, 0,0,0, 0,0));
    v.rst = 1;
    step(v, ex(0,0,0,0, 0, 32'h100, 0, 0,0,0, 0,0));
    v = nop();
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,0));
    // Zero-stall load after reset
    v = nop(); v.dren = 1; v.outv = 32'h10; v.dhit = 1; v.load = 32'h12345678; v.wen = 1; v.wsel = 2;
    step(v, ex(1,0,0,0, 0, 32'h10, 0, 0,0,0, 0,0));
    v = nop();
    step(v, ex(0,0,0,0, 0, 0, 0, 1,2,32'h12345678, 0,0));

`ifdef MEMSTAGE_WATCHDOG_EN
    // Eight stall cycles reach the limit of 8; error is sticky afterwards
    v = nop(); v.dren = 1; v.outv = 32'h20; v.wen = 1; v.wsel = 4; v.load = 32'hA5A5;
    step(v, ex(1,0,1,0, 0, 32'h20, 0, 0,0,0, 0,0));
    for (int i = 1; i < 8; i++) step(v, ex(1,0,1,0, 0, 32'h20, 0, 0,0,0, 0,0));
    v.dhit = 1;
    step(v, ex(1,0,0,0, 0, 32'h20, 0, 0,0,0, 0,1));
    v = nop();
    step(v, ex(0,0,0,0, 0, 0, 0, 1,4,32'hA5A5, 0,1));
    step(v, ex(0,0,0,0, 0, 0, 0, 0,0,0, 0,1));
`endif

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
